alu_issue_ctrl: RTL and testbench

// Initiator side of the PE ALU interface. Accepts operation requests over a valid/ready port and

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_issue_wdog.sv | 33 +++
 rtl/alu_issue_ctrl.sv | 129 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared between the PE ALU and its issue controller.
//   - ALU_Sel operation codes (5 bits); codes above ALU_OP_MAX are invalid.
//   - FSM state encoding used by alu_issue_ctrl.
//   - op_is_valid(): opcode range check.
package alu_pkg;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_AND    = 5'b00010;
    localparam logic [4:0] ALU_OR     = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_NOR    = 5'b00101;
    localparam logic [4:0] ALU_NAND   = 5'b00110;
    localparam logic [4:0] ALU_XNOR   = 5'b00111;
    localparam logic [4:0] ALU_SLT    = 5'b01000;
    localparam logic [4:0] ALU_SLTU   = 5'b01001;
    localparam logic [4:0] ALU_SLL    = 5'b01010;
    localparam logic [4:0] ALU_SRL    = 5'b01011;
    localparam logic [4:0] ALU_ROL    = 5'b01100;
    localparam logic [4:0] ALU_ROR    = 5'b01101;
    localparam logic [4:0] ALU_PASSB  = 5'b01110;
    localparam logic [4:0] ALU_SRA    = 5'b01111;
    localparam logic [4:0] ALU_LB     = 5'b10000;
    localparam logic [4:0] ALU_LH     = 5'b10001;
    localparam logic [4:0] ALU_LBU    = 5'b10010;
    localparam logic [4:0] ALU_LHU    = 5'b10011;
    localparam logic [4:0] ALU_OP_MAX = 5'b10011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } issue_state_e;

    function automatic logic op_is_valid(input logic [4:0] op);
        return (op <= ALU_OP_MAX);
    endfunction

endpackage

// File: rtl/alu_issue_wdog.sv
// alu_issue_wdog: wait-cycle counter for alu_issue_ctrl.
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   clear   forces the count back to 0 (held while not waiting)
//   enable  advances the count by one per cycle
//   expired high while the count equals TIMEOUT-1
// The count saturates at TIMEOUT-1 so expired cannot wrap back low.
module alu_issue_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the PE ALU interface.
// Takes one request at a time over a valid/ready port, presents the operands to
// the ALU, waits for ALUcomplete (bounded by TIMEOUT wait cycles) and returns
// the captured result, Zero flag and tag over a valid/ready response port.
// Opcodes above ALU_OP_MAX and hung operations produce an error response.
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/ready/a/b/op/tag     request port
//   alu_a/b/sel                    operands to the ALU (held between operations)
//   alu_out/zero/complete          ALU results
//   rsp_valid/ready/data/zero/tag/err  response port
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [4:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_complete,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    issue_state_e state_q;
    issue_state_e state_d;
    logic         accept;
    logic         wdog_expired;

    assign accept = (state_q == ST_IDLE) && req_valid;

    alu_issue_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != ST_WAIT),
        .enable  (state_q == ST_WAIT),
        .expired (wdog_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = op_is_valid(req_op) ? ST_ISSUE : ST_RESP;
                end
            end
            // ALUcomplete seen here belongs to a previous operation.
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (alu_complete || wdog_expired) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand and response registers. Operands only change on a valid accept,
    // so the ALU inputs stay quiet while idle and across rejected opcodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= ALU_ADD;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_tag  <= '0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            rsp_tag <= req_tag;
            if (op_is_valid(req_op)) begin
                alu_a   <= req_a;
                alu_b   <= req_b;
                alu_sel <= req_op;
            end else begin
                rsp_data <= '0;
                rsp_zero <= 1'b0;
                rsp_err  <= 1'b1;
            end
        end else if (state_q == ST_WAIT) begin
            // Completion wins over expiry when both land in the same cycle.
            if (alu_complete) begin
                rsp_data <= alu_out;
                rsp_zero <= alu_zero;
                rsp_err  <= 1'b0;
            end else if (wdog_expired) begin
                rsp_data <= '0;
                rsp_zero <= 1'b0;
                rsp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int WIDTH   = 32;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic [4:0]       req_op = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    logic             alu_complete;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    alu_issue_ctrl #(
        .WIDTH   (WIDTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .req_tag      (req_tag),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_complete (alu_complete),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_zero     (rsp_zero),
        .rsp_tag      (rsp_tag),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: combinational result, completion pulse at a programmed cycle.
    int comp_cycle  = -1;
    int stale_cycle = -1;
    always_comb begin
        alu_out = '0;
        case (alu_sel)
            ALU_ADD:  alu_out = alu_a + alu_b;
            ALU_SUB:  alu_out = alu_a - alu_b;
            ALU_SLTU: alu_out = {31'b0, (alu_a < alu_b)};
            default:  alu_out = '0;
        endcase
    end
    assign alu_zero     = (alu_out == '0);
    assign alu_complete = (cyc == comp_cycle) || (cyc == stale_cycle);

    int n_tot = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tot++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               at;
    } exp_t;

    exp_t sb[$];

    // Monitor: pops one expectation per response, then checks it is held.
    logic             in_rsp = 1'b0;
    logic [WIDTH-1:0] h_data;
    logic             h_zero;
    logic [TAG_W-1:0] h_tag;
    logic             h_err;
    always @(negedge clk) begin
        exp_t e;
        if (rst || !rsp_valid) begin
            in_rsp = 1'b0;
        end else begin
            check("req_ready_in_resp", req_ready, 0);
            if (!in_rsp) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_cycle", cyc, e.at);
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_zero", rsp_zero, e.zero);
                    check("rsp_tag", rsp_tag, e.tag);
                    check("rsp_err", rsp_err, e.err);
                end
                h_data = rsp_data; h_zero = rsp_zero; h_tag = rsp_tag; h_err = rsp_err;
                in_rsp = 1'b1;
            end else begin
                check("hold_data", rsp_data, h_data);
                check("hold_zero", rsp_zero, h_zero);
                check("hold_tag", rsp_tag, h_tag);
                check("hold_err", rsp_err, h_err);
            end
        end
    end

    // Present a request, record the accept cycle n and push the expected response.
    // delay < 0 means the ALU never completes; lat is the hand-computed accept-to-rsp_valid latency.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                         input logic [3:0] tag, input int delay, input bit push,
                         input logic [31:0] edata, input logic ezero, input logic eerr,
                         input int lat, output int n);
        int w;
        @(negedge clk);
        req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) check("accept_timeout", 0, 1);
        n = cyc;
        if (push) sb.push_back('{data: edata, zero: ezero, tag: tag, err: eerr, at: n + lat});
        comp_cycle = (delay < 0) ? -1 : n + 2 + delay;
        @(negedge clk);
        req_valid = 1'b0;
        req_a = 32'hDEAD_BEEF; req_b = 32'hFFFF_FFFF; req_op = 5'b11111; req_tag = 4'hF;
    endtask

    task automatic wait_done(input string nm);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(sb.size() == 0 && !rsp_valid) && w < 60);
        check(nm, (sb.size() == 0 && !rsp_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int w;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_zero", rsp_zero, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_sel", alu_sel, ALU_ADD);

        // 1: ADD 5+3, immediate completion
        issue(5, 3, ALU_ADD, 4'd3, 0, 1'b1, 8, 1'b0, 1'b0, 3, n);
        wait_done("t1_done");

        // 2: SUB 5-5 after 4 cycles; a stale complete during ISSUE must be ignored
        issue(5, 5, ALU_SUB, 4'd2, 4, 1'b1, 0, 1'b1, 1'b0, 7, n);
        stale_cycle = n + 1;
        wait_done("t2_done");
        stale_cycle = -1;

        // 3: invalid opcode, ALU operands untouched
        issue(32'h77, 32'h88, 5'b10100, 4'd9, -1, 1'b1, 0, 1'b0, 1'b1, 1, n);
        wait_done("t3_done");
        check("t3_alu_a_kept", alu_a, 5);
        check("t3_alu_b_kept", alu_b, 5);
        check("t3_alu_sel_kept", alu_sel, ALU_SUB);

        // 4: ALU never completes -> error after 16 WAIT cycles
        issue(7, 1, ALU_ADD, 4'd4, -1, 1'b1, 0, 1'b0, 1'b1, 18, n);
        wait_done("t4_done");

        // 5: SLTU 5<10 with 3 cycles of response backpressure
        rsp_ready = 1'b0;
        issue(5, 10, ALU_SLTU, 4'd7, 2, 1'b1, 1, 1'b0, 1'b0, 5, n);
        w = 0;
        while (!rsp_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("t5_rsp_seen", rsp_valid, 1);
        repeat (3) @(negedge clk);
        check("t5_still_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        wait_done("t5_done");

        // 6: reset while waiting -> no response, back to reset values
        issue(9, 9, ALU_ADD, 4'd6, -1, 1'b0, 0, 1'b0, 1'b0, 0, n);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_req_ready", req_ready, 1);
        check("t6_alu_a", alu_a, 0);
        check("t6_alu_sel", alu_sel, ALU_ADD);
        check("t6_rsp_tag", rsp_tag, 0);
        repeat (25) @(negedge clk);
        check("t6_no_rsp", rsp_valid, 0);

        // Recovery after reset: ADD 1+2 with delay 1
        issue(1, 2, ALU_ADD, 4'd5, 1, 1'b1, 3, 1'b0, 1'b0, 4, n);
        wait_done("t7_done");

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
